// File: rtl/rca_seq16.sv
// Serial 16-bit add/subtract: one 4-bit ripple-carry nibble per clock, LSB first.
// Define RCA_SEQ16_OVF_EN to build the signed-overflow flag; otherwise it is tied to 0.
module rca_seq16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] src1,
  input  logic [15:0] src2,
  input  logic        sub_flag,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] sum,
  output logic        carry_out,
  output logic        overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] a_reg, a_next;
  logic [15:0] b_reg, b_next;
  logic [15:0] sum_reg, sum_next;
  logic [1:0]  cnt_reg, cnt_next;
  logic        carry_reg, carry_next;
  logic        carry_out_reg, carry_out_next;

  logic        accept;
  logic        last_nibble;
  logic [3:0]  nib_a;
  logic [3:0]  nib_b;
  logic [3:0]  slice_sum;
  logic [4:0]  slice_c;

  assign accept      = in_valid && (state_reg == IDLE);
  assign last_nibble = (cnt_reg == 2'd3);

  // Operand nibble selected by the counter feeds the shared ripple slice.
  always_comb begin
    nib_a = a_reg[3:0];
    nib_b = b_reg[3:0];
    case (cnt_reg)
      2'd0: begin nib_a = a_reg[3:0];   nib_b = b_reg[3:0];   end
      2'd1: begin nib_a = a_reg[7:4];   nib_b = b_reg[7:4];   end
      2'd2: begin nib_a = a_reg[11:8];  nib_b = b_reg[11:8];  end
      default: begin nib_a = a_reg[15:12]; nib_b = b_reg[15:12]; end
    endcase
  end

  assign slice_c[0] = carry_reg;
  for (genvar gi = 0; gi < 4; gi++) begin : g_fa
    assign slice_sum[gi]  = nib_a[gi] ^ nib_b[gi] ^ slice_c[gi];
    assign slice_c[gi+1]  = (nib_a[gi] & nib_b[gi]) | (slice_c[gi] & (nib_a[gi] ^ nib_b[gi]));
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = CALC;
      CALC:    if (last_nibble) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    a_next         = a_reg;
    b_next         = b_reg;
    sum_next       = sum_reg;
    cnt_next       = cnt_reg;
    carry_next     = carry_reg;
    carry_out_next = carry_out_reg;
    if (accept) begin
      // Subtraction is a + ~b + 1: invert b here and seed the carry with sub_flag.
      a_next         = src1;
      b_next         = sub_flag ? ~src2 : src2;
      carry_next     = sub_flag;
      cnt_next       = 2'd0;
      sum_next       = 16'h0000;
      carry_out_next = 1'b0;
    end else if (state_reg == CALC) begin
      case (cnt_reg)
        2'd0:    sum_next[3:0]   = slice_sum;
        2'd1:    sum_next[7:4]   = slice_sum;
        2'd2:    sum_next[11:8]  = slice_sum;
        default: sum_next[15:12] = slice_sum;
      endcase
      carry_next = slice_c[4];
      cnt_next   = cnt_reg + 2'd1;
      if (last_nibble) carry_out_next = slice_c[4];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      a_reg         <= 16'h0000;
      b_reg         <= 16'h0000;
      sum_reg       <= 16'h0000;
      cnt_reg       <= 2'd0;
      carry_reg     <= 1'b0;
      carry_out_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      a_reg         <= a_next;
      b_reg         <= b_next;
      sum_reg       <= sum_next;
      cnt_reg       <= cnt_next;
      carry_reg     <= carry_next;
      carry_out_reg <= carry_out_next;
    end
  end

`ifdef RCA_SEQ16_OVF_EN
  logic overflow_reg, overflow_next;

  // Same-sign operands whose result sign differs; slice_sum[3] is the final sum[15].
  always_comb begin
    overflow_next = overflow_reg;
    if (accept) begin
      overflow_next = 1'b0;
    end else if ((state_reg == CALC) && last_nibble) begin
      overflow_next = (a_reg[15] == b_reg[15]) && (slice_sum[3] != a_reg[15]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow_reg <= 1'b0;
    else     overflow_reg <= overflow_next;
  end

  assign overflow = overflow_reg;
`else
  assign overflow = 1'b0;
`endif

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign sum       = sum_reg;
  assign carry_out = carry_out_reg;

endmodule

// File: tb/tb_rca_seq16.sv
// Directed self-checking bench for rca_seq16: arithmetic, latency, handshake hold and async abort.
module tb_rca_seq16;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] src1;
  logic [15:0] src2;
  logic        sub_flag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        carry_out;
  logic        overflow;

  int checks = 0;
  int fails  = 0;

`ifdef RCA_SEQ16_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  rca_seq16 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .src1(src1), .src2(src2), .sub_flag(sub_flag), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .carry_out(carry_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Present one operand set for exactly one rising edge, then scramble the inputs.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic s);
    @(negedge clk);
    src1 = a; src2 = b; sub_flag = s; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; src1 = 16'hDEAD; src2 = 16'hBEEF; sub_flag = ~s;
  endtask

  // Edges elapsed after the accept edge until out_valid is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vec(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic [15:0] exp_sum, input logic exp_c,
                         input logic exp_v);
    int lat;
    start_op(a, b, s);
    wait_done(lat);
    checks++;
    if (lat !== 4) begin fails++; $display("FAIL %s latency: got %0d need 4", name, lat); end
    checks++;
    if (sum !== exp_sum) begin fails++; $display("FAIL %s sum: got %h need %h", name, sum, exp_sum); end
    checks++;
    if (carry_out !== exp_c) begin fails++; $display("FAIL %s carry_out: got %b need %b", name, carry_out, exp_c); end
    checks++;
    if (overflow !== exp_v) begin fails++; $display("FAIL %s overflow: got %b need %b", name, overflow, exp_v); end
    $display("txn %s: %h %s %h -> sum=%h c=%b v=%b lat=%0d", name, a, s ? "-" : "+", b, sum, carry_out, overflow, lat);
    @(negedge clk);
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL reset handshake: got in_ready=%b out_valid=%b need 1/0", in_ready, out_valid);
    end
    checks++;
    if (sum !== 16'h0000 || carry_out !== 1'b0 || overflow !== 1'b0) begin
      fails++; $display("FAIL reset outputs: got %h/%b/%b need 0000/0/0", sum, carry_out, overflow);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    $display("txn reset released");
  endtask

  task automatic test_add;
    run_vec("add", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL add return_idle: got in_ready=%b out_valid=%b need 1/0", in_ready, out_valid);
    end
    checks++;
    if (sum !== 16'h5555) begin fails++; $display("FAIL add idle_hold: got %h need 5555", sum); end
    run_vec("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic test_sub;
    run_vec("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_vec("sub_noborrow", 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0);
    run_vec("sub_chain", 16'h1000, 16'h0001, 1'b1, 16'h0FFF, 1'b1, 1'b0);
  endtask

  task automatic test_overflow;
    run_vec("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, OVF_ON);
    run_vec("ovf_sub", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, OVF_ON);
  endtask

  task automatic test_hold;
    int lat;
    int bad = 0;
    out_ready = 1'b0;
    start_op(16'hA5A5, 16'h1111, 1'b0);
    wait_done(lat);
    for (int i = 0; i < 10; i++) begin
      src1 = src1 ^ 16'hFFFF; src2 = src2 + 16'h0101; in_valid = ~in_valid;
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 16'hB6B6 || carry_out !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin fails++; $display("FAIL hold stable: got %0d bad cycles need 0 (sum=%h)", bad, sum); end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL hold release: got in_ready=%b out_valid=%b need 1/0", in_ready, out_valid);
    end
    checks++;
    if (sum !== 16'hB6B6) begin fails++; $display("FAIL hold idle_sum: got %h need b6b6", sum); end
    $display("txn hold: held 10 cycles, sum=%h lat=%0d", sum, lat);
  endtask

  task automatic test_abort;
    start_op(16'h1111, 16'h2222, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL abort handshake: got out_valid=%b in_ready=%b need 0/1", out_valid, in_ready);
    end
    checks++;
    if (sum !== 16'h0000 || carry_out !== 1'b0) begin
      fails++; $display("FAIL abort clear: got sum=%h c=%b need 0000/0", sum, carry_out);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    $display("txn abort: reset mid-calc");
    run_vec("after_abort", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; src1 = 16'h0; src2 = 16'h0; sub_flag = 1'b0; out_ready = 1'b1;
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_hold();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/rca_seq16.md
RCA_SEQ16 -- requirements
Module: rca_seq16

Interface
REQ-001 Parameters SHALL be none; all widths are fixed as listed below.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  operand set presented.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 src1  input  16  first operand.
REQ-007 src2  input  16  second operand.
REQ-008 sub_flag  input  1  1 = src1 - src2, 0 = src1 + src2.
REQ-009 out_valid  output  1  result held on sum/carry_out/overflow.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 sum  output  16  result, modulo 2^16.
REQ-012 carry_out  output  1  carry out of bit 15 (subtract: 1 = no borrow).
REQ-013 overflow  output  1  two's-complement signed overflow (see REQ-030).

Function
REQ-014 The block SHALL compute the 16-bit add/subtract serially, one 4-bit nibble per clock, LSB nibble first, using a 4-bit ripple-carry slice with a registered inter-nibble carry.
REQ-015 The FSM SHALL have states IDLE, CALC, DONE.
REQ-016 in_ready SHALL be 1 in IDLE only.
REQ-017 out_valid SHALL be 1 in DONE only.
REQ-018 On an accept (in_valid && in_ready at a clock edge), the block SHALL latch src1, latch src2 (bitwise-inverted if sub_flag=1), load carry register = sub_flag, clear nibble counter to 0, clear the sum register, and enter CALC.
REQ-019 In IDLE without in_valid, the state and registers SHALL hold.
REQ-020 In CALC, each edge SHALL write slice sum to sum[4k+3:4k] for counter k, load the slice carry into the carry register, and increment k.
REQ-021 On the edge processing k=3, the block SHALL load carry_out from the slice carry and enter DONE.
REQ-022 Latency: for an accept at edge N, out_valid SHALL be 1 after edge N+4.
REQ-023 In DONE, sum/carry_out/overflow SHALL stay stable while out_ready=0.
REQ-024 DONE with out_ready=1 at an edge SHALL return to IDLE; a new accept is possible no earlier than the next edge (no overlap, max throughput 1 per 6 cycles).
REQ-025 src1/src2/sub_flag/in_valid changes during CALC or DONE SHALL be ignored.
REQ-026 sum, carry_out and overflow SHALL stay visible in IDLE until the next accept clears them.
REQ-027 Nibble counter SHALL be 2 bits and wrap from 3 to 0; it never advances outside CALC.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, in_ready=1, out_valid=0, sum=0, carry_out=0, overflow=0, carry register=0, counter=0, operand registers=0, regardless of the clock.
REQ-029 Reset asserted mid-CALC or in DONE SHALL abort the operation with no result delivered; the first accept is possible on the first edge after rst deasserts.

Configuration
REQ-030 With RCA_SEQ16_OVF_EN defined, the block SHALL set overflow on the k=3 edge as (latched src1[15] == effective src2[15]) && (sum[15] != src1[15]), where effective src2 is src2 after subtract inversion.
REQ-031 Without RCA_SEQ16_OVF_EN, overflow SHALL be tied to constant 0 and no overflow logic SHALL be built; all other behaviour SHALL be identical.

Verification
REQ-032 Add 0x1234 + 0x4321, out_ready=1 -> out_valid 4 cycles after accept, sum=0x5555, carry_out=0, overflow=0.
REQ-033 Add 0xFFFF + 0x0001 -> sum=0x0000, carry_out=1 (carry ripples through all 4 nibbles), overflow=0.
REQ-034 Subtract 0x0005 - 0x0007 -> sum=0xFFFE, carry_out=0; subtract 0x0007 - 0x0005 -> sum=0x0002, carry_out=1.
REQ-035 Add 0x7FFF + 0x0001 -> sum=0x8000, overflow=1 with RCA_SEQ16_OVF_EN, overflow=0 without it.
REQ-036 Hold out_ready=0 for 10 cycles in DONE and toggle src1/src2/in_valid -> outputs stable, in_ready=0; then out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-037 Assert rst asynchronously after 2 CALC cycles -> out_valid=0, sum=0, in_ready=1 immediately; a fresh 0x0001 + 0x0001 after release -> sum=0x0002.
